// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    localparam int unsigned WORD_W = 32;
    localparam logic [WORD_W-1:0] PC_INCR = 32'd4;
    localparam logic [WORD_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        StFetch,
        StSkid,
        StDrain
    } fetch_state_e;

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry store for a returned instruction word and its PC+4 while IF/ID is occupied.
module fetch_skid_buffer
    import fetch_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              clear,
    input  logic [WORD_W-1:0] data_in,
    input  logic [WORD_W-1:0] pc_plus4_in,
    output logic [WORD_W-1:0] data,
    output logic [WORD_W-1:0] pc_plus4,
    output logic              valid
);

    logic [WORD_W-1:0] data_q;
    logic [WORD_W-1:0] pc_plus4_q;
    logic              valid_q;

    // Clear wins over load so a redirect always empties the entry.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            valid_q <= 1'b0;
        end else if (load) begin
            valid_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q     <= '0;
            pc_plus4_q <= '0;
        end else if (load) begin
            data_q     <= data_in;
            pc_plus4_q <= pc_plus4_in;
        end
    end

    assign data     = data_q;
    assign pc_plus4 = pc_plus4_q;
    assign valid    = valid_q;

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage with request/valid memory handshake, skid entry and redirect drain.
// Optional FETCH_COUNT_EN adds a FetchCount output counting IF/ID loads.
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Stall,
    input  logic              Redirect,
    input  logic [WORD_W-1:0] RedirectPC,
    output logic              ImemReq,
    output logic [WORD_W-1:0] ImemAddr,
    input  logic              ImemValid,
    input  logic [WORD_W-1:0] ImemData,
    output logic [WORD_W-1:0] Instruction,
    output logic [WORD_W-1:0] PCPlus4,
    output logic              InstrValid
`ifdef FETCH_COUNT_EN
    ,
    output logic [WORD_W-1:0] FetchCount
`endif
);

    fetch_state_e      state_q, state_d;
    logic [WORD_W-1:0] pc_q, pc_d;
    logic [WORD_W-1:0] addr_q, addr_d;
    logic              req_q, req_d;
    logic [WORD_W-1:0] instr_q, instr_d;
    logic [WORD_W-1:0] pc_plus4_q, pc_plus4_d;
    logic              valid_q, valid_d;

    logic              slot_free;
    logic              done;
    logic              outstanding;
    logic [WORD_W-1:0] addr_plus4;
    logic              skid_load;
    logic              skid_clear;
    logic [WORD_W-1:0] skid_data;
    logic [WORD_W-1:0] skid_pc_plus4;
    logic              skid_valid;

    assign slot_free   = !valid_q || !Stall;
    assign done        = req_q && ImemValid;
    assign outstanding = req_q && !ImemValid;
    assign addr_plus4  = addr_q + PC_INCR;

    fetch_skid_buffer u_skid (
        .clk         (Clk),
        .reset       (Reset),
        .load        (skid_load),
        .clear       (skid_clear),
        .data_in     (ImemData),
        .pc_plus4_in (addr_plus4),
        .data        (skid_data),
        .pc_plus4    (skid_pc_plus4),
        .valid       (skid_valid)
    );

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        pc_plus4_d = pc_plus4_q;
        valid_d    = valid_q;
        skid_load  = 1'b0;
        skid_clear = 1'b0;

        if (valid_q && !Stall) begin
            valid_d = 1'b0;
        end

        if (Redirect) begin
            pc_d       = RedirectPC;
            valid_d    = 1'b0;
            skid_clear = 1'b1;
            // A word still in flight must be swallowed before the new address goes out.
            state_d    = outstanding ? StDrain : StFetch;
        end else begin
            case (state_q)
                StFetch: begin
                    if (done) begin
                        pc_d = pc_q + PC_INCR;
                        if (slot_free) begin
                            instr_d    = ImemData;
                            pc_plus4_d = addr_plus4;
                            valid_d    = 1'b1;
                        end else begin
                            skid_load = 1'b1;
                            state_d   = StSkid;
                        end
                    end
                end
                StSkid: begin
                    if (slot_free && skid_valid) begin
                        instr_d    = skid_data;
                        pc_plus4_d = skid_pc_plus4;
                        valid_d    = 1'b1;
                        skid_clear = 1'b1;
                        state_d    = StFetch;
                    end
                end
                StDrain: begin
                    if (ImemValid) begin
                        state_d = StFetch;
                    end
                end
                default: state_d = StFetch;
            endcase
        end

        // Request address only moves once the current request has completed.
        addr_d = outstanding ? addr_q : pc_d;
        req_d  = (state_d != StSkid);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= StFetch;
            pc_q       <= RESET_PC;
            addr_q     <= RESET_PC;
            req_q      <= 1'b0;
            instr_q    <= '0;
            pc_plus4_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            addr_q     <= addr_d;
            req_q      <= req_d;
            instr_q    <= instr_d;
            pc_plus4_q <= pc_plus4_d;
            valid_q    <= valid_d;
        end
    end

    assign ImemReq     = req_q;
    assign ImemAddr    = addr_q;
    assign Instruction = instr_q;
    assign PCPlus4     = pc_plus4_q;
    assign InstrValid  = valid_q;

`ifdef FETCH_COUNT_EN
    logic [WORD_W-1:0] count_q;
    logic              load_ifid;

    // A live word in IF/ID next cycle while the slot was free means a fresh load.
    assign load_ifid = valid_d && slot_free;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            count_q <= '0;
        end else if (load_ifid) begin
            count_q <= count_q + 32'd1;
        end
    end

    assign FetchCount = count_q;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a variable-latency memory responder.
module tb_instruction_fetch;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Stall;
    logic        Redirect;
    logic [31:0] RedirectPC;
    logic        ImemReq;
    logic [31:0] ImemAddr;
    logic        ImemValid = 1'b0;
    logic [31:0] ImemData = '0;
    logic [31:0] Instruction;
    logic [31:0] PCPlus4;
    logic        InstrValid;

    logic        ImemReq2;
    logic [31:0] ImemAddr2;
    logic [31:0] Instruction2;
    logic [31:0] PCPlus42;
    logic        InstrValid2;
`ifdef FETCH_COUNT_EN
    logic [31:0] FetchCount;
    logic [31:0] FetchCount2;
`endif

    int checks = 0;
    int errors = 0;
    int lat = 1;
    int cnt = 0;
    bit busy = 1'b0;

    always #5 Clk = ~Clk;

    instruction_fetch dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .Stall       (Stall),
        .Redirect    (Redirect),
        .RedirectPC  (RedirectPC),
        .ImemReq     (ImemReq),
        .ImemAddr    (ImemAddr),
        .ImemValid   (ImemValid),
        .ImemData    (ImemData),
        .Instruction (Instruction),
        .PCPlus4     (PCPlus4),
        .InstrValid  (InstrValid)
`ifdef FETCH_COUNT_EN
        ,
        .FetchCount  (FetchCount)
`endif
    );

    // Shares the memory responder; timing matches dut while neither stalls nor redirects.
    instruction_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .Clk         (Clk),
        .Reset       (Reset),
        .Stall       (1'b0),
        .Redirect    (1'b0),
        .RedirectPC  (32'h0),
        .ImemReq     (ImemReq2),
        .ImemAddr    (ImemAddr2),
        .ImemValid   (ImemValid),
        .ImemData    (ImemData),
        .Instruction (Instruction2),
        .PCPlus4     (PCPlus42),
        .InstrValid  (InstrValid2)
`ifdef FETCH_COUNT_EN
        ,
        .FetchCount  (FetchCount2)
`endif
    );

    // Memory: word at address a is {16'hC0DE, a[15:0]}, returned lat cycles after request seen.
    always @(posedge Clk) begin
        if (Reset) begin
            busy = 1'b0;
            ImemValid <= 1'b0;
        end else if (ImemValid) begin
            busy = 1'b0;
            ImemValid <= 1'b0;
        end else if (busy) begin
            cnt = cnt - 1;
            if (cnt == 0) begin
                ImemValid <= 1'b1;
                ImemData  <= {16'hC0DE, ImemAddr[15:0]};
            end
        end else if (ImemReq) begin
            busy = 1'b1;
            cnt = lat - 1;
            if (cnt == 0) begin
                ImemValid <= 1'b1;
                ImemData  <= {16'hC0DE, ImemAddr[15:0]};
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        Reset = 1'b1;
        Stall = 1'b0;
        Redirect = 1'b0;
        RedirectPC = '0;
        step();
        step();
        check("rst_req", 32'(ImemReq), 32'd0);
        check("rst_valid", 32'(InstrValid), 32'd0);
        check("rst_instr", Instruction, 32'h0);
        check("rst_pcp4", PCPlus4, 32'h0);
        check("rst_addr", ImemAddr, 32'h0);

        // Reset must beat a simultaneous redirect.
        Redirect = 1'b1;
        RedirectPC = 32'h100;
        step();
        check("rst_over_redir_addr", ImemAddr, 32'h0);
        check("rst_over_redir_req", 32'(ImemReq), 32'd0);
        Redirect = 1'b0;
        Reset = 1'b0;

        // Latency 1 streaming.
        step();
        check("first_req", 32'(ImemReq), 32'd1);
        check("first_addr", ImemAddr, 32'h0);
        check("wrap_first_addr", ImemAddr2, 32'hFFFF_FFFC);
        check("first_valid", 32'(InstrValid), 32'd0);
        step();
        check("addr0_hold", ImemAddr, 32'h0);
        step();
        check("w0_valid", 32'(InstrValid), 32'd1);
        check("w0_instr", Instruction, 32'hC0DE_0000);
        check("w0_pcp4", PCPlus4, 32'h4);
        check("addr4", ImemAddr, 32'h4);
        check("wrap_second_addr", ImemAddr2, 32'h0);
        step();
        check("consume_drop", 32'(InstrValid), 32'd0);
        check("addr4_hold", ImemAddr, 32'h4);
        step();
        check("w4_instr", Instruction, 32'hC0DE_0004);
        check("w4_pcp4", PCPlus4, 32'h8);
        check("addr8", ImemAddr, 32'h8);
        step();
        step();
        check("w8_pcp4", PCPlus4, 32'hC);
        check("addrC", ImemAddr, 32'hC);
        step();
        step();
        check("wC_instr", Instruction, 32'hC0DE_000C);
        check("wC_pcp4", PCPlus4, 32'h10);
        check("addr10", ImemAddr, 32'h10);

        // Stall for three cycles while the 0x10 word returns.
        Stall = 1'b1;
        step();
        check("stall_hold_valid", 32'(InstrValid), 32'd1);
        check("stall_hold_instr", Instruction, 32'hC0DE_000C);
        check("stall_req", 32'(ImemReq), 32'd1);
        step();
        check("skid_req_low", 32'(ImemReq), 32'd0);
        check("skid_instr_kept", Instruction, 32'hC0DE_000C);
        step();
        check("skid_req_low2", 32'(ImemReq), 32'd0);
        check("skid_pcp4_kept", PCPlus4, 32'h10);
        Stall = 1'b0;
        step();
        check("skid_out_instr", Instruction, 32'hC0DE_0010);
        check("skid_out_pcp4", PCPlus4, 32'h14);
        check("skid_out_valid", 32'(InstrValid), 32'd1);
        check("resume_req", 32'(ImemReq), 32'd1);
        check("resume_addr", ImemAddr, 32'h14);
        step();
        check("skid_no_dup", 32'(InstrValid), 32'd0);
        step();
        check("w14_instr", Instruction, 32'hC0DE_0014);
        check("w14_pcp4", PCPlus4, 32'h18);
        check("addr18", ImemAddr, 32'h18);

        // Redirect together with Stall in the cycle the 0x18 word returns.
        Stall = 1'b1;
        step();
        check("pre_redir_valid", 32'(InstrValid), 32'd1);
        check("pre_redir_imemvalid", 32'(ImemValid), 32'd1);
        Redirect = 1'b1;
        RedirectPC = 32'h8;
        step();
        check("redir_stall_valid", 32'(InstrValid), 32'd0);
        check("redir_stall_addr", ImemAddr, 32'h8);
        check("redir_stall_req", 32'(ImemReq), 32'd1);
        Redirect = 1'b0;
        Stall = 1'b0;
        lat = 3;

        // Redirect while the 0x8 request is outstanding; second redirect in DRAIN wins.
        step();
        check("lat3_addr8", ImemAddr, 32'h8);
        Redirect = 1'b1;
        RedirectPC = 32'h80;
        step();
        check("drain_addr_kept", ImemAddr, 32'h8);
        check("drain_req", 32'(ImemReq), 32'd1);
        check("drain_valid", 32'(InstrValid), 32'd0);
        RedirectPC = 32'h40;
        step();
        check("drain_addr_kept2", ImemAddr, 32'h8);
        check("drain_word_back", 32'(ImemValid), 32'd1);
        check("drain_valid2", 32'(InstrValid), 32'd0);
        Redirect = 1'b0;
        step();
        check("drain_done_addr", ImemAddr, 32'h40);
        check("drain_dropped", 32'(InstrValid), 32'd0);
        step();
        step();
        step();
        step();
        check("w40_valid", 32'(InstrValid), 32'd1);
        check("w40_instr", Instruction, 32'hC0DE_0040);
        check("w40_pcp4", PCPlus4, 32'h44);
`ifdef FETCH_COUNT_EN
        check("fetch_count", FetchCount, 32'd7);
`endif

        // Reset while the 0x44 request is outstanding.
        Reset = 1'b1;
        step();
        check("rst2_req", 32'(ImemReq), 32'd0);
        check("rst2_valid", 32'(InstrValid), 32'd0);
        check("rst2_instr", Instruction, 32'h0);
        check("rst2_pcp4", PCPlus4, 32'h0);
        check("rst2_addr", ImemAddr, 32'h0);
`ifdef FETCH_COUNT_EN
        check("rst2_count", FetchCount, 32'd0);
`endif
        Reset = 1'b0;
        step();
        check("rst2_first_req", 32'(ImemReq), 32'd1);
        check("rst2_first_addr", ImemAddr, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
